// File: rtl/egress_tx_pkt_buf.sv
// Store-and-forward egress packet buffer between a port's read channel and its MAC TX,
// with a forced inter-packet gap. Optional counters are enabled by `TX_STATS_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module egress_tx_pkt_buf #(
  parameter int DW         = `DATA_WIDTH,
  parameter int DEPTH      = 64,
  parameter int IPG_CYCLES = 3
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iRdSop,
  input  logic          iRdEop,
  input  logic          iRdVld,
  input  logic [DW-1:0] iRdData,
  input  logic          iRdLast,
  output logic          oRdRdy,
  output logic          oTxSop,
  output logic          oTxEop,
  output logic          oTxVld,
  output logic [DW-1:0] oTxData,
  input  logic          iTxRdy,
  output logic [31:0]   oTxPktCnt,
  output logic [15:0]   oErrCnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DW + 2;
  localparam logic [3:0] GAP_LOAD = 4'((IPG_CYCLES > 1) ? IPG_CYCLES - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic          rdy_q, rdy_d;
  logic          in_pkt_q, in_pkt_d;
  logic          tx_vld_q, tx_vld_d;
  logic          tx_sop_q, tx_sop_d;
  logic          tx_eop_q, tx_eop_d;
  logic [DW-1:0] tx_data_q, tx_data_d;

  logic          full, empty, wr_en, rd_en, eop_wr, eop_tx, start, wr_sop;
  logic [EW-1:0] head;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en  = iRdVld & rdy_q;
  assign eop_wr = wr_en & iRdEop;
  assign eop_tx = tx_vld_q & tx_eop_q & iTxRdy;
  assign head   = mem_q[rd_ptr_q[AW-1:0]];
  // Stored Sop simply reflects packet state: this both drops a duplicate Sop and forces a missing one.
  assign wr_sop = ~in_pkt_q;
  // An Eop arriving this cycle lets the head go out one cycle earlier; full with no
  // complete packet means an oversize packet that must go cut-through.
  assign start  = ~empty & ((pkt_cnt_q != '0) | eop_wr | full);

  always_ff @(posedge iClk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {wr_sop, iRdEop, iRdData};
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(wr_en);
    rd_ptr_d  = rd_ptr_q + PW'(rd_en);
    rdy_d     = ~((wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    in_pkt_d  = wr_en ? ~iRdEop : in_pkt_q;
    pkt_cnt_d = pkt_cnt_q + CW'(eop_wr) - CW'(eop_tx);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      gap_cnt_q <= '0;
      rdy_q     <= 1'b0;
      in_pkt_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_sop_q  <= 1'b0;
      tx_eop_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rdy_q     <= rdy_d;
      in_pkt_q  <= in_pkt_d;
      tx_vld_q  <= tx_vld_d;
      tx_sop_q  <= tx_sop_d;
      tx_eop_q  <= tx_eop_d;
      tx_data_q <= tx_data_d;
    end
  end

  // The last gap cycle is spent in IDLE, which already launches the next packet.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SEND;
      S_SEND: begin
        if (eop_tx) begin
          if (IPG_CYCLES > 1) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      S_IDLE:  rd_en = start;
      S_SEND:  rd_en = ~empty & (~tx_vld_q | (iTxRdy & ~tx_eop_q));
      default: rd_en = 1'b0;
    endcase
    tx_vld_d  = tx_vld_q;
    tx_sop_d  = tx_sop_q;
    tx_eop_d  = tx_eop_q;
    tx_data_d = tx_data_q;
    if (tx_vld_q & iTxRdy) begin
      tx_vld_d = 1'b0;
      tx_sop_d = 1'b0;
      tx_eop_d = 1'b0;
    end
    if (rd_en) begin
      tx_vld_d = 1'b1;
      {tx_sop_d, tx_eop_d, tx_data_d} = head;
    end
  end

  assign oRdRdy  = rdy_q;
  assign oTxVld  = tx_vld_q;
  assign oTxSop  = tx_sop_q;
  assign oTxEop  = tx_eop_q;
  assign oTxData = tx_data_q;

`ifdef TX_STATS_EN
  logic [31:0] tx_pkt_cnt_q, tx_pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [1:0]  err_num;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    err_num = 2'(wr_en & in_pkt_q & iRdSop) + 2'(wr_en & ~in_pkt_q & ~iRdSop)
            + 2'(wr_en & iRdLast & ~iRdEop);
    tx_pkt_cnt_d = tx_pkt_cnt_q + 32'(eop_tx);
    err_cnt_d    = sat_add16(err_cnt_q, err_num);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      tx_pkt_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      tx_pkt_cnt_q <= tx_pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign oTxPktCnt = tx_pkt_cnt_q;
  assign oErrCnt   = err_cnt_q;
`else
  logic unused_framing;
  assign unused_framing = iRdSop ^ iRdLast;
  assign oTxPktCnt      = '0;
  assign oErrCnt        = '0;
`endif

endmodule

// File: tb/tb_egress_tx_pkt_buf.sv
// Bench for egress_tx_pkt_buf: table-driven packet scenarios, timing sequences and
// randomized traffic checked against an expected-word queue built from each sent packet.
module tb_egress_tx_pkt_buf;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int IPG = 3;
`ifdef TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          iClk, iRst_n, iRdSop, iRdEop, iRdVld, iRdLast, iTxRdy;
  logic [DW-1:0] iRdData;
  logic          oRdRdy, oTxSop, oTxEop, oTxVld;
  logic [DW-1:0] oTxData;
  logic [31:0]   oTxPktCnt;
  logic [15:0]   oErrCnt;

  egress_tx_pkt_buf #(.DW(DW), .DEPTH(DEPTH), .IPG_CYCLES(IPG)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iRdSop(iRdSop), .iRdEop(iRdEop), .iRdVld(iRdVld),
    .iRdData(iRdData), .iRdLast(iRdLast), .oRdRdy(oRdRdy), .oTxSop(oTxSop),
    .oTxEop(oTxEop), .oTxVld(oTxVld), .oTxData(oTxData), .iTxRdy(iTxRdy),
    .oTxPktCnt(oTxPktCnt), .oErrCnt(oErrCnt));

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every packet handed to the DUT becomes a queue of {sop,eop,data} words,
  // with Sop only on the first word and Eop only on the last, whatever framing was driven.
  logic [DW+1:0] exp_q[$];
  int            sop_cyc[$], eop_cyc[$];
  int            cyc = 0;
  int            tx_words = 0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] prev_data;
  bit            rnd_rdy = 1'b0;
  int            acc_cnt = 0;
  int            stall_at = 1000;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    if (!iRst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_vld", 64'(oTxVld), 64'd1);
        check("hold_data", 64'(oTxData), 64'(prev_data));
      end
      if (oTxVld && iTxRdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got word %0h with nothing outstanding", oTxData);
        end else begin
          logic [DW+1:0] e;
          e = exp_q.pop_front();
          if ({oTxSop, oTxEop, oTxData} !== e) begin
            errors++;
            $display("FAIL tx_word: got %0h expected %0h", {oTxSop, oTxEop, oTxData}, e);
          end
        end
        if (oTxSop) sop_cyc.push_back(cyc);
        if (oTxEop) eop_cyc.push_back(cyc);
        tx_words++;
      end
      hold_prev = oTxVld && !iTxRdy;
      prev_data = oTxData;
    end
  end

  initial begin
    iTxRdy = 1'b1;
    forever begin
      @(posedge iClk);
      #1;
      iTxRdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic put_word(input logic sop, input logic eop, input logic last,
                          input logic [DW-1:0] d);
    bit acc;
    int t;
    iRdVld = 1'b1; iRdSop = sop; iRdEop = eop; iRdLast = last; iRdData = d;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 5000) begin
      @(negedge iClk);
      acc = oRdRdy;
      if (!acc && stall_at < 0) stall_at = acc_cnt;
      @(posedge iClk);
      #1;
      t++;
    end
    checks++;
    if (acc) acc_cnt++;
    else begin
      errors++;
      $display("FAIL put_word_timeout: got no oRdRdy required 1 within %0d cycles", t);
    end
    iRdVld = 1'b0; iRdSop = 1'b0; iRdEop = 1'b0; iRdLast = 1'b0;
  endtask

  task automatic send_packet(input int len, input int sop_at, input int last_at,
                             input bit drop_sop, input int base, input bit gaps);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == 0), (i == len - 1), DW'(base + i)});
    for (int i = 0; i < len; i++) begin
      put_word(((i == 0) && !drop_sop) || (i == sop_at), (i == len - 1),
               (i == len - 1) || (i == last_at), DW'(base + i));
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge iClk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || oTxVld) && t < 4000) begin
      @(posedge iClk);
      #1;
      t++;
    end
    repeat (IPG + 2) begin
      @(posedge iClk);
      #1;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int len; int sop_at; int last_at; bit drop_sop; bit rnd; int base; int exp_err;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   t1_seq[8];
    int   exp_pkt, exp_err, w0;

    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    vec_t tbl[8];
    int   t1_seq[8];
    int   exp_pkt, exp_err, w0;

    tbl[0] = '{16, -1, -1, 1'b0, 1'b1, 'h000, 0};  // data 0..15 under random backpressure
    tbl[1] = '{ 6,  2,  3, 1'b0, 1'b0, 'h500, 2};  // Sop mid-packet, then Last without Eop
    tbl[2] = '{ 1, -1, -1, 1'b0, 1'b1, 'h600, 0};
    tbl[3] = '{ 9, -1,  4, 1'b0, 1'b1, 'h700, 1};
    tbl[4] = '{ 3,  1, -1, 1'b0, 1'b1, 'h800, 1};
    tbl[5] = '{ 5, -1, -1, 1'b1, 1'b0, 'h900, 1};  // first word lacks Sop
    tbl[6] = '{ 2,  1,  0, 1'b0, 1'b1, 'hA00, 2};
    tbl[7] = '{12, -1, -1, 1'b0, 1'b1, 'hB00, 0};
    t1_seq = '{1, 1, 1, 1, 0, 0, 0, 0};
    exp_pkt = 0;
    exp_err = 0;

    iRst_n = 1'b0; iRdVld = 1'b0; iRdSop = 1'b0; iRdEop = 1'b0; iRdLast = 1'b0;
    iRdData = '0;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_rdy", 64'(oRdRdy), 64'd0);
    check("rst_vld", 64'(oTxVld), 64'd0);
    check("rst_sop", 64'(oTxSop), 64'd0);
    check("rst_eop", 64'(oTxEop), 64'd0);
    check("rst_data", 64'(oTxData), 64'd0);
    check("rst_pktcnt", 64'(oTxPktCnt), 64'd0);
    check("rst_errcnt", 64'(oErrCnt), 64'd0);
    #3;
    iRst_n = 1'b1;
    @(posedge iClk);
    #1;
    check("rdy_after_release", 64'(oRdRdy), 64'd1);

    // 4-word packet: first word out the cycle after w3, 4 words, then 3 idle cycles.
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), (i == 3), DW'('hA0 + i)});
    for (int i = 0; i < 3; i++) put_word((i == 0), 1'b0, 1'b0, DW'('hA0 + i));
    check("t1_no_early_vld", 64'(oTxVld), 64'd0);
    put_word(1'b0, 1'b1, 1'b1, DW'('hA3));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_vld_%0d", k), 64'(oTxVld), 64'(t1_seq[k]));
      @(posedge iClk);
      #1;
    end
    drain();
    exp_pkt++;
    check("t1_pktcnt", 64'(oTxPktCnt), STATS ? 64'(exp_pkt) : 64'd0);

    // Two back-to-back single-word packets: next Sop 4 cycles after first Eop.
    sop_cyc.delete();
    eop_cyc.delete();
    send_packet(1, -1, -1, 1'b0, 'hB0, 1'b0);
    send_packet(1, -1, -1, 1'b0, 'hB1, 1'b0);
    drain();
    exp_pkt += 2;
    check("t2_sop_count", 64'(sop_cyc.size()), 64'd2);
    if (sop_cyc.size() >= 2 && eop_cyc.size() >= 1)
      check("t2_ipg", 64'(sop_cyc[1] - eop_cyc[0]), 64'd4);

    // Oversize packet: stall at DEPTH words, then cut-through.
    acc_cnt = 0;
    stall_at = -1;
    w0 = tx_words;
    send_packet(70, -1, -1, 1'b0, 'h1000, 1'b0);
    drain();
    exp_pkt++;
    check("t3_stall_at", 64'(stall_at), 64'(DEPTH));
    check("t3_words", 64'(tx_words - w0), 64'd70);
    check("t3_errcnt", 64'(oErrCnt), 64'd0);
    stall_at = 1000;

    for (int v = 0; v < 8; v++) begin
      rnd_rdy = tbl[v].rnd;
      w0 = tx_words;
      send_packet(tbl[v].len, tbl[v].sop_at, tbl[v].last_at, tbl[v].drop_sop,
                  tbl[v].base, 1'b0);
      drain();
      exp_pkt++;
      exp_err += tbl[v].exp_err;
      check($sformatf("vec%0d_words", v), 64'(tx_words - w0), 64'(tbl[v].len));
      check($sformatf("vec%0d_errcnt", v), 64'(oErrCnt), STATS ? 64'(exp_err) : 64'd0);
      check($sformatf("vec%0d_pktcnt", v), 64'(oTxPktCnt), STATS ? 64'(exp_pkt) : 64'd0);
    end

    // Randomized back-to-back traffic with input bubbles and random backpressure.
    rnd_rdy = 1'b1;
    w0 = tx_words;
    begin
      int total;
      total = 0;
      for (int p = 0; p < 25; p++) begin
        int len;
        len = $urandom_range(1, 24);
        total += len;
        send_packet(len, -1, -1, 1'b0, $urandom_range(0, 'hFFFF) << 8, 1'b1);
        exp_pkt++;
      end
      drain();
      check("rnd_words", 64'(tx_words - w0), 64'(total));
    end
    check("rnd_pktcnt", 64'(oTxPktCnt), STATS ? 64'(exp_pkt) : 64'd0);
    check("rnd_errcnt", 64'(oErrCnt), STATS ? 64'(exp_err) : 64'd0);

    // Reset mid-packet: outputs clear without a clock edge, next packet is clean.
    rnd_rdy = 1'b0;
    for (int i = 0; i < 5; i++) put_word((i == 0), 1'b0, 1'b0, DW'('hD0 + i));
    @(posedge iClk);
    #3;
    iRst_n = 1'b0;
    #1;
    check("t6_rdy", 64'(oRdRdy), 64'd0);
    check("t6_vld", 64'(oTxVld), 64'd0);
    check("t6_sop", 64'(oTxSop), 64'd0);
    check("t6_eop", 64'(oTxEop), 64'd0);
    check("t6_data", 64'(oTxData), 64'd0);
    check("t6_pktcnt", 64'(oTxPktCnt), 64'd0);
    check("t6_errcnt", 64'(oErrCnt), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge iClk);
    #3;
    iRst_n = 1'b1;
    @(posedge iClk);
    #1;
    w0 = tx_words;
    send_packet(10, -1, -1, 1'b0, 'hE00, 1'b0);
    drain();
    check("t6_words", 64'(tx_words - w0), 64'd10);
    check("t6_pktcnt_after", 64'(oTxPktCnt), STATS ? 64'd1 : 64'd0);
    check("t6_errcnt_after", 64'(oErrCnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
